// File: rtl/parser_wait_segs.sv
// Purpose: captures the first C_NUM_SEGS beats of a header-tap packet for the parsing stage.
// Latency: segs_valid rises 1 cycle after the final accepted beat; vlan_out_valid pulses 1 cycle after the first.
// Backpressure: s_axis_tready drops while a captured packet waits in OUTPUT for segs_ready.
//
// Ports: axis_clk/aresetn (sync, active-low) | s_axis_* header tap input |
//        tdata_segs/tuser_1st + segs_valid/segs_ready to the parser | vlan_out/vlan_out_valid lookup key.
// Build option: PARSER_WAIT_SEGS_ZERO_FILL_EN clears all segments when a new packet starts,
//               so segments past the end of a short packet read as 0 instead of stale data.
module parser_wait_segs #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 16,
    parameter int C_VLANID_WIDTH     = 12
) (
    input  logic                                    axis_clk,
    input  logic                                    aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
    input  logic                                    s_axis_tvalid,
    input  logic                                    s_axis_tlast,
    output logic                                    s_axis_tready,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
    output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
    output logic                                    segs_valid,
    input  logic                                    segs_ready,
    output logic [C_VLANID_WIDTH-1:0]               vlan_out,
    output logic                                    vlan_out_valid
);

    localparam int CNT_W = $clog2(C_NUM_SEGS) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(C_NUM_SEGS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_NUM_SEGS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t                                  state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_q, segs_d;
    logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_q, tuser_d;
    logic [C_VLANID_WIDTH-1:0]               vlan_q, vlan_d;
    logic                                    vlan_vld_q, vlan_vld_d;
    logic                                    segs_valid_q, segs_valid_d;
    logic                                    beat_acc;
    logic                                    seg_wr;

    assign s_axis_tready  = (state_q != OUTPUT);
    assign beat_acc       = s_axis_tvalid && s_axis_tready;

    assign tdata_segs     = segs_q;
    assign tuser_1st      = tuser_q;
    assign vlan_out       = vlan_q;
    assign vlan_out_valid = vlan_vld_q;
    assign segs_valid     = segs_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        segs_d     = segs_q;
        tuser_d    = tuser_q;
        vlan_d     = vlan_q;
        vlan_vld_d = 1'b0;
        seg_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (beat_acc) begin
`ifdef PARSER_WAIT_SEGS_ZERO_FILL_EN
                    segs_d = '0;
`else
                    segs_d = segs_q;
`endif
                    seg_wr     = 1'b1;
                    cnt_d      = CNT_ONE;
                    tuser_d    = s_axis_tuser;
                    vlan_d     = s_axis_tdata[116 +: C_VLANID_WIDTH];
                    vlan_vld_d = 1'b1;
                    state_d    = s_axis_tlast ? OUTPUT : COLLECT;
                end
            end
            COLLECT: begin
                if (beat_acc) begin
                    // Guard only matters when C_NUM_SEGS==1 (IDLE already filled the single slot).
                    seg_wr = (cnt_q < CNT_MAX);
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (s_axis_tlast) begin
                        state_d = OUTPUT;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat_acc) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (s_axis_tlast) begin
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (segs_valid_q && segs_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // cnt_q is the index of the beat being accepted (0 in IDLE).
        if (seg_wr) begin
            for (int k = 0; k < C_NUM_SEGS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    segs_d[k*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] = s_axis_tdata;
                end
            end
        end

        segs_valid_d = (state_d == OUTPUT);
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            segs_q       <= '0;
            tuser_q      <= '0;
            vlan_q       <= '0;
            vlan_vld_q   <= 1'b0;
            segs_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            segs_q       <= segs_d;
            tuser_q      <= tuser_d;
            vlan_q       <= vlan_d;
            vlan_vld_q   <= vlan_vld_d;
            segs_valid_q <= segs_valid_d;
        end
    end

endmodule

// File: tb/tb_parser_wait_segs.sv
// Purpose: self-checking bench for parser_wait_segs against a per-packet reference model.
// Latency: expects segs_valid one cycle after the final beat, vlan_out_valid one cycle after the first.
// Backpressure: holds segs_ready low for random stretches while offering beats that must be refused.
module tb_parser_wait_segs;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NS = 16;
    localparam int VW = 12;

    logic             axis_clk = 1'b0;
    logic             aresetn;
    logic [DW-1:0]    s_axis_tdata;
    logic [UW-1:0]    s_axis_tuser;
    logic             s_axis_tvalid;
    logic             s_axis_tlast;
    logic             s_axis_tready;
    logic [NS*DW-1:0] tdata_segs;
    logic [UW-1:0]    tuser_1st;
    logic             segs_valid;
    logic             segs_ready;
    logic [VW-1:0]    vlan_out;
    logic             vlan_out_valid;

    parser_wait_segs #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_NUM_SEGS        (NS),
        .C_VLANID_WIDTH    (VW)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .tdata_segs    (tdata_segs),
        .tuser_1st     (tuser_1st),
        .segs_valid    (segs_valid),
        .segs_ready    (segs_ready),
        .vlan_out      (vlan_out),
        .vlan_out_valid(vlan_out_valid)
    );

    always #5 axis_clk = ~axis_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the parser should see after each packet.
    logic [DW-1:0] exp_seg [NS];
    logic [UW-1:0] exp_tuser;
    logic [VW-1:0] exp_vlan;
    bit            vv_exp;
    logic [DW-1:0] pkt [$];
    logic [UW-1:0] pkt_user;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rnd128();
        logic [DW-1:0] r;
        r = rnd256();
        return r[UW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NS; k++) exp_seg[k] = '0;
        exp_tuser = '0;
        exp_vlan  = '0;
        vv_exp    = 1'b0;
    endtask

    task automatic model_packet();
        logic [DW-1:0] b0;
`ifdef PARSER_WAIT_SEGS_ZERO_FILL_EN
        for (int k = 0; k < NS; k++) exp_seg[k] = '0;
`endif
        for (int k = 0; k < pkt.size() && k < NS; k++) exp_seg[k] = pkt[k];
        b0        = pkt[0];
        exp_tuser = pkt_user;
        exp_vlan  = b0[116 +: VW];
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < NS; k++)
            chk($sformatf("%s seg%0d", tag, k), tdata_segs[k*DW +: DW], exp_seg[k]);
        chk({tag, " tuser_1st"}, tuser_1st, exp_tuser);
        chk({tag, " vlan_out"}, vlan_out, exp_vlan);
    endtask

    // Advance to the next sampling point and check the one-cycle vlan pulse.
    task automatic cyc();
        @(negedge axis_clk);
        chk("vlan_out_valid", vlan_out_valid, vv_exp);
        vv_exp = 1'b0;
    endtask

    task automatic drive_beat(input int i, input int n);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pkt[i];
        s_axis_tlast  = (i == n - 1);
        s_axis_tuser  = (i == 0) ? pkt_user : rnd128();
        vv_exp        = (i == 0);
    endtask

    task automatic run_pkt(input int wait_n, input bit gaps);
        int n;
        n = pkt.size();
        model_packet();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    cyc();
                    chk("gap segs_valid", segs_valid, 1'b0);
                    s_axis_tvalid = 1'b0;
                    s_axis_tdata  = rnd256();
                end
            end
            cyc();
            chk("segs_valid before last", segs_valid, 1'b0);
            chk("tready while collecting", s_axis_tready, 1'b1);
            drive_beat(i, n);
        end
        for (int w = 0; w <= wait_n; w++) begin
            cyc();
            chk("segs_valid held", segs_valid, 1'b1);
            chk("tready in output", s_axis_tready, 1'b0);
            check_outputs("out");
            // Offer beats that must be refused while the segments are pending.
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rnd256();
            s_axis_tuser  = rnd128();
            s_axis_tlast  = 1'($urandom_range(0, 1));
            segs_ready    = (w == wait_n);
        end
        cyc();
        chk("segs_valid after handshake", segs_valid, 1'b0);
        chk("tready after handshake", s_axis_tready, 1'b1);
        s_axis_tvalid = 1'b0;
        segs_ready    = 1'b0;
    endtask

    task automatic fill_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(rnd256());
        pkt_user = rnd128();
    endtask

    initial begin
        logic [DW-1:0] b;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        segs_ready    = 1'b0;
        model_reset();
        repeat (3) @(negedge axis_clk);
        chk("reset segs_valid", segs_valid, 1'b0);
        chk("reset vlan_out_valid", vlan_out_valid, 1'b0);
        chk("reset tready", s_axis_tready, 1'b1);
        check_outputs("reset");
        aresetn = 1'b1;

        // Single-beat packet carrying VLAN 0x00A.
        fill_random(1);
        b = pkt[0];
        b[116 +: VW] = 12'h00A;
        pkt[0] = b;
        run_pkt(0, 1'b0);

        // Three beats with recognisable byte patterns.
        pkt.delete();
        pkt.push_back({32{8'h11}});
        pkt.push_back({32{8'h22}});
        pkt.push_back({32{8'h33}});
        pkt_user = rnd128();
        run_pkt(0, 1'b0);

        // Longer than the capture window: beats 16..19 are dropped.
        fill_random(20);
        run_pkt(0, 1'b0);

        // Parser stalls for five cycles.
        fill_random(3);
        run_pkt(5, 1'b0);

        // Short packet after a 3-beat one: stale vs zero-filled tail segments.
        fill_random(3);
        run_pkt(0, 1'b0);
        fill_random(1);
        run_pkt(0, 1'b0);

        // Reset during beat 2 of a 5-beat packet.
        fill_random(5);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pre-reset segs_valid", segs_valid, 1'b0);
            drive_beat(i, 5);
            if (i == 2) aresetn = 1'b0;
        end
        model_reset();
        cyc();
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        chk("post-reset segs_valid", segs_valid, 1'b0);
        chk("post-reset tready", s_axis_tready, 1'b1);
        check_outputs("post-reset");
        fill_random(4);
        run_pkt(1, 1'b0);

        // Random traffic.
        for (int p = 0; p < 40; p++) begin
            fill_random($urandom_range(1, 20));
            run_pkt($urandom_range(0, 4), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
